// File: rtl/vga_pkg.sv
// vga_pkg: shared raster timing constants and the index type for the VGA
// text path. The constants are the 640x480@60 defaults (800x525 total).
// The derived sync windows are half-open: [HS_START, HS_END) and
// [VS_START, VS_END). vga_idx_t is the 10-bit pixel/line index type used by
// this block and by every downstream stage.
`timescale 1ns/1ps
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam int IDX_W = 10;
  typedef logic [IDX_W-1:0] vga_idx_t;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (pixels within a line, or lines within a
// frame). Steps once per clock while step is high and wraps TOTAL-1 -> 0.
// sync and visible are registered from the next count value, so they always
// describe the count shown in the same cycle.
// Ports:
//   clk25mhz  pixel clock
//   rst_n     asynchronous reset, active low
//   step      advance the counter this clock
//   count     current index, 0..TOTAL-1
//   sync      sync pulse, polarity set by ACTIVE_LOW
//   visible   count < VISIBLE
//   wrap      combinational: count is at TOTAL-1 (the next step wraps)
`timescale 1ns/1ps
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE    = 640,
  parameter int FRONT      = 16,
  parameter int SYNC       = 96,
  parameter int BACK       = 48,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic     clk25mhz,
  input  logic     rst_n,
  input  logic     step,
  output vga_idx_t count,
  output logic     sync,
  output logic     visible,
  output logic     wrap
);

  localparam int TOTAL   = VISIBLE + FRONT + SYNC + BACK;
  localparam int S_START = VISIBLE + FRONT;
  localparam int S_END   = S_START + SYNC;
  localparam vga_idx_t LAST = vga_idx_t'(TOTAL - 1);

  vga_idx_t count_nxt;
  logic     sync_nxt;
  logic     vis_nxt;

  // wrap is left combinational so the vertical axis can step on the same
  // edge where the horizontal axis rolls over.
  assign wrap = (count == LAST);

  always_comb begin
    count_nxt = wrap ? '0 : count + vga_idx_t'(1);
    // Window test done in int so S_END == 1024 still compares correctly.
    sync_nxt  = ((int'(count_nxt) >= S_START) && (int'(count_nxt) < S_END)) ^ ACTIVE_LOW;
    vis_nxt   = (int'(count_nxt) < VISIBLE);
  end

  always_ff @(posedge clk25mhz or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      sync    <= ACTIVE_LOW;
      visible <= 1'b1;
    end else if (step) begin
      count   <= count_nxt;
      sync    <= sync_nxt;
      visible <= vis_nxt;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// vga_timing: free-running raster timing generator for the 25 MHz VGA text
// path. All status outputs are cycle-aligned with hindex/vindex.
// Ports:
//   clk25mhz     pixel clock
//   rst_n        asynchronous reset, active low
//   enable       count enable; when low all state holds
//   hindex       pixel counter, 0..H_TOTAL-1
//   vindex       line counter, 0..V_TOTAL-1
//   hsync/vsync  sync pulses, low during the pulse when SYNC_ACTIVE_LOW
//   visible      inside the active picture area
//   line_end     one-cycle strobe at hindex == H_TOTAL-1
//   frame_start  one-cycle strobe when the counters wrap to 0,0
//   blink        toggles every BLINK_FRAMES frames
`timescale 1ns/1ps
module vga_timing #(
  parameter int H_VISIBLE       = vga_pkg::H_VISIBLE,
  parameter int H_FRONT         = vga_pkg::H_FRONT,
  parameter int H_SYNC          = vga_pkg::H_SYNC,
  parameter int H_BACK          = vga_pkg::H_BACK,
  parameter int V_VISIBLE       = vga_pkg::V_VISIBLE,
  parameter int V_FRONT         = vga_pkg::V_FRONT,
  parameter int V_SYNC          = vga_pkg::V_SYNC,
  parameter int V_BACK          = vga_pkg::V_BACK,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int BLINK_FRAMES    = 30
) (
  input  logic              clk25mhz,
  input  logic              rst_n,
  input  logic              enable,
  output vga_pkg::vga_idx_t hindex,
  output vga_pkg::vga_idx_t vindex,
  output logic              hsync,
  output logic              vsync,
  output logic              visible,
  output logic              line_end,
  output logic              frame_start,
  output logic              blink
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 2 || V_TOTAL < 1 || BLINK_FRAMES < 1) begin : g_bad_cfg
      $error("vga_timing: totals must be within 2..1024 (H) / 1..1024 (V) and BLINK_FRAMES >= 1");
    end
  endgenerate

  vga_pkg::vga_idx_t h_count;
  vga_pkg::vga_idx_t v_count;
  logic h_wrap, v_wrap;
  logic h_vis, v_vis;
  logic v_step;
  logic frame_wrap;
  logic [BLINK_W-1:0] frame_cnt;

  assign v_step     = enable & h_wrap;
  assign frame_wrap = enable & h_wrap & v_wrap;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .ACTIVE_LOW(SYNC_ACTIVE_LOW)
  ) u_h (
    .clk25mhz(clk25mhz), .rst_n(rst_n), .step(enable),
    .count(h_count), .sync(hsync), .visible(h_vis), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .ACTIVE_LOW(SYNC_ACTIVE_LOW)
  ) u_v (
    .clk25mhz(clk25mhz), .rst_n(rst_n), .step(v_step),
    .count(v_count), .sync(vsync), .visible(v_vis), .wrap(v_wrap)
  );

  assign hindex  = h_count;
  assign vindex  = v_count;
  assign visible = h_vis & v_vis;

  // Strobes look one count ahead so they land in the cycle that shows the
  // matching index; both are forced low while counting is paused.
  always_ff @(posedge clk25mhz or negedge rst_n) begin
    if (!rst_n) begin
      line_end    <= 1'b0;
      frame_start <= 1'b0;
      blink       <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      line_end    <= enable && (int'(h_count) == H_TOTAL - 2);
      frame_start <= frame_wrap;
      if (frame_wrap) begin
        if (frame_cnt == BLINK_LAST) begin
          frame_cnt <= '0;
          blink     <= ~blink;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
`timescale 1ns/1ps
module tb_vga_timing;

  logic clk25mhz = 1'b0;
  logic rst_n    = 1'b0;
  logic enable   = 1'b1;

  // Default 640x480 instance: horizontal timing, enable hold, async reset.
  logic [9:0] a_h, a_v;
  logic a_hs, a_vs, a_vis, a_le, a_fs, a_bl;
  // Small instance (16x11 total, active-high syncs, blink every 3 frames):
  // whole-frame, vsync and blink behaviour within a short run.
  logic [9:0] b_h, b_v;
  logic b_hs, b_vs, b_vis, b_le, b_fs, b_bl;

  int tests = 0;
  int fails = 0;

  always #20 clk25mhz = ~clk25mhz;

  vga_timing dut_a (
    .clk25mhz(clk25mhz), .rst_n(rst_n), .enable(enable),
    .hindex(a_h), .vindex(a_v), .hsync(a_hs), .vsync(a_vs),
    .visible(a_vis), .line_end(a_le), .frame_start(a_fs), .blink(a_bl)
  );

  vga_timing #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .SYNC_ACTIVE_LOW(1'b0), .BLINK_FRAMES(3)
  ) dut_b (
    .clk25mhz(clk25mhz), .rst_n(rst_n), .enable(enable),
    .hindex(b_h), .vindex(b_v), .hsync(b_hs), .vsync(b_vs),
    .visible(b_vis), .line_end(b_le), .frame_start(b_fs), .blink(b_bl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk25mhz);
  endtask

  // Step until dut_b shows frame_start; n = cycles taken (bounded).
  task automatic wait_fs(output int n);
    n = 0;
    do begin
      adv(1);
      n++;
    end while (!b_fs && n < 400);
    chk("b_fs_seen", b_fs, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int vs_on, hs_on, le_n, fs_n, vis_n, vs_err;

    // Reset held for 5 cycles
    adv(5);
    chk("rst_h", a_h, 0);
    chk("rst_v", a_v, 0);
    chk("rst_hsync", a_hs, 1);
    chk("rst_vsync", a_vs, 1);
    chk("rst_visible", a_vis, 1);
    chk("rst_line_end", a_le, 0);
    chk("rst_frame_start", a_fs, 0);
    chk("rst_blink", a_bl, 0);
    chk("rst_b_hsync", b_hs, 0);
    chk("rst_b_vsync", b_vs, 0);

    // Release: counting 0,1,2,...
    rst_n = 1'b1;
    chk("rel_h0", a_h, 0);
    for (int i = 1; i <= 5; i++) begin
      adv(1);
      chk("run_h", a_h, i);
      chk("run_v", a_v, 0);
      chk("run_hsync", a_hs, 1);
      chk("run_visible", a_vis, 1);
      chk("run_fs", a_fs, 0);
    end

    // Edge of the visible area
    adv(634);
    chk("h639", a_h, 639);
    chk("vis639", a_vis, 1);
    adv(1);
    chk("h640", a_h, 640);
    chk("vis640", a_vis, 0);

    // Pause at hindex 640 for 10 cycles
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      adv(1);
      chk("hold_h", a_h, 640);
      chk("hold_le", a_le, 0);
      chk("hold_hsync", a_hs, 1);
      chk("hold_vsync", a_vs, 1);
    end
    chk("hold_b_h", b_h, 0);
    chk("hold_b_v", b_v, 7);
    enable = 1'b1;
    adv(1);
    chk("resume_h", a_h, 641);

    // hsync window 656..751, active low
    adv(14);
    chk("hs655", a_hs, 1);
    adv(1);
    chk("hs656", a_hs, 0);
    adv(95);
    chk("h751", a_h, 751);
    chk("hs751", a_hs, 0);
    adv(1);
    chk("hs752", a_hs, 1);

    // End of line
    adv(46);
    chk("le798", a_le, 0);
    adv(1);
    chk("h799", a_h, 799);
    chk("le799", a_le, 1);
    chk("v799", a_v, 0);
    adv(1);
    chk("wrap_h", a_h, 0);
    chk("wrap_v", a_v, 1);
    chk("wrap_le", a_le, 0);
    chk("wrap_fs", a_fs, 0);

    // Asynchronous reset mid-cycle at hindex 300, vindex 1
    adv(300);
    chk("pre_rst_h", a_h, 300);
    #7 rst_n = 1'b0;
    #1;
    chk("arst_h", a_h, 0);
    chk("arst_v", a_v, 0);
    chk("arst_hsync", a_hs, 1);
    chk("arst_visible", a_vis, 1);
    chk("arst_le", a_le, 0);
    chk("arst_b_h", b_h, 0);
    adv(2);
    rst_n = 1'b1;
    chk("rel2_h", a_h, 0);
    chk("rel2_v", a_v, 0);
    adv(1);
    chk("rel2_h1", a_h, 1);
    chk("rel2_v1", a_v, 0);

    // Small instance: first frame_start after 176 cycles (16x11)
    wait_fs(n);
    chk("b_fs1_delay", n, 175);
    chk("b_fs1_h", b_h, 0);
    chk("b_fs1_v", b_v, 0);
    chk("b_fs1_blink", b_bl, 0);

    // One full frame of the small instance
    vs_on = 0; hs_on = 0; le_n = 0; fs_n = 0; vis_n = 0; vs_err = 0;
    for (int i = 0; i < 176; i++) begin
      adv(1);
      if (b_vs) vs_on++;
      if (b_hs) hs_on++;
      if (b_le) le_n++;
      if (b_fs) fs_n++;
      if (b_vis) vis_n++;
      if (b_vs !== ((b_v == 7) || (b_v == 8))) vs_err++;
    end
    chk("b_vsync_cycles", vs_on, 32);
    chk("b_vsync_lines", vs_err, 0);
    chk("b_hsync_cycles", hs_on, 33);
    chk("b_line_ends", le_n, 11);
    chk("b_frame_starts", fs_n, 1);
    chk("b_visible_cycles", vis_n, 48);
    chk("b_fs2_now", b_fs, 1);
    chk("b_fs2_blink", b_bl, 0);

    // Blink toggles at frame 3 and back at frame 6
    wait_fs(n);
    chk("b_fs3_delay", n, 176);
    chk("b_fs3_blink", b_bl, 1);
    adv(1);
    chk("b_fs3_pulse", b_fs, 0);
    chk("b_fs3_blink_hold", b_bl, 1);
    wait_fs(n);
    chk("b_fs4_blink", b_bl, 1);
    wait_fs(n);
    chk("b_fs5_blink", b_bl, 1);
    wait_fs(n);
    chk("b_fs6_blink", b_bl, 0);
    chk("a_no_fs", a_fs, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Upstream raster timing generator for the 25 MHz VGA text path.
- Produces the free-running pixel and line counters (hindex, vindex) consumed by the text renderer and font stages.
- Also produces hsync/vsync, a visible-area flag, line/frame strobes and a blink phase, all cycle-aligned to the counters.
- Default timing is 640x480@60 (800x525 total).

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync are low during the pulse
- BLINK_FRAMES, 30, frames per blink half-period

Ports:
- clk25mhz  in  1  pixel clock
- rst_n  in  1  asynchronous reset, active low
- enable  in  1  count enable; when low all state holds
- hindex  out  10  horizontal counter, 0..H_TOTAL-1
- vindex  out  10  vertical counter, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync  out  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- visible  out  1  high when hindex < H_VISIBLE and vindex < V_VISIBLE
- line_end  out  1  one-cycle strobe when hindex == H_TOTAL-1
- frame_start  out  1  one-cycle strobe when hindex == 0 and vindex == 0
- blink  out  1  toggles every BLINK_FRAMES frames

Behaviour:
- Reset: asynchronous and active low. All outputs are driven from registers.
  - hindex = 0, vindex = 0.
  - hsync and vsync at their inactive level.
  - visible = 1, line_end = 0, blink = 0, internal frame counter = 0.
  - frame_start = 0. It first rises at the first wrap to 0,0 after reset, not at reset itself.
- Totals: H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters. Both must be at most 1024 (checked in elaboration).
- Horizontal counter: with enable high, hindex increments by 1 per clock and wraps H_TOTAL-1 -> 0.
- Vertical counter: vindex increments on the same edge where hindex wraps. It wraps V_TOTAL-1 -> 0 when both counters are at their maximum.
- enable low: counters, syncs, blink and the frame counter all hold. line_end and frame_start are forced to 0.
- Alignment: every status output is valid in the same cycle as the hindex/vindex value it describes (zero relative latency). Implement by computing from the next-state counter values.
  - hsync is active while H_VISIBLE+H_FRONT <= hindex < H_VISIBLE+H_FRONT+H_SYNC (default 656..751).
  - vsync is active while V_VISIBLE+V_FRONT <= vindex < V_VISIBLE+V_FRONT+V_SYNC (default 490..491). It is independent of hindex.
  - line_end is high in the single cycle where hindex == H_TOTAL-1, on every line including blanking lines.
  - frame_start is high only in the cycle where the counters show 0,0 after a wrap.
- Blink: the frame counter increments on each frame_start. On reaching BLINK_FRAMES-1 it clears and toggles blink. The toggle is visible in the frame_start cycle.
- Downstream contract: the text renderer treats hindex == 640 as its end-of-row event and vindex 2..477 as its rendered region. Both counters must therefore step through every value with no skips.
- Reset mid-frame: the asynchronous clear takes effect immediately. Counting restarts at 0,0 on the first enabled edge after release.

Decomposition:
- Shared package vga_pkg holds:
  - the timing constants (the defaults above);
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END;
  - a 10-bit index typedef used by this block and all downstream stages.
- One natural sub-module, vga_axis_counter, instantiated twice (horizontal and vertical). It has parameters for the visible, front, sync and back sizes and polarity, plus a step input. Its outputs are count, sync, visible and wrap.

Test Plan:
- Reset held 5 cycles, then release with enable=1 -> hindex 0,1,2,... each cycle; vindex = 0; hsync = 1; visible = 1; blink = 0.
- Run to hindex 655/656/751/752 -> hsync 1/0/0/1 (active low). line_end = 1 only at 799, where the next cycle shows hindex = 0 and vindex = 1.
- Run a full frame -> vsync = 0 exactly on lines 490–491 (1600 cycles). frame_start pulses once per 420000 cycles, at 0,0.
- Drop enable at hindex = 640 for 10 cycles -> hindex stays 640, line_end = 0, syncs unchanged. Counting resumes at 641 after enable returns.
- Run 30 frames -> blink toggles 0 -> 1 at the start of frame 30 and back to 0 at frame 60.
- Assert rst_n at hindex = 300, vindex = 200, asynchronously mid-cycle -> outputs immediately return to reset values. After release, counting restarts at 0,0.
